sparc_ctrl_seq: RTL

Multi-cycle control sequencer for the SPARC datapath. Decodes the instruction register, steps the datapath through fetch / decode / execute / memory / write-back, and drives every load enable and the memory strobes. Waits on the RAM handshake with a bounded timeout. Sits beside `DataPath`, replacing ad-hoc enables; the `finish` strobe halts it cleanly.

---
 rtl/sparc_ctrl_pkg.sv | 53 +++++
 rtl/sparc_ctrl_decode.sv | 41 ++++
 rtl/sparc_ctrl_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sparc_ctrl_pkg.sv
// Shared encodings for the SPARC multi-cycle control sequencer:
// state codes, instruction field constants and decode result types.
package sparc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_FWAIT  = 4'd2,
    S_DECODE = 4'd3,
    S_ALU    = 4'd4,
    S_LADDR  = 4'd5,
    S_LWAIT  = 4'd6,
    S_LWB    = 4'd7,
    S_SADDR  = 4'd8,
    S_SWAIT  = 4'd9,
    S_BRANCH = 4'd10,
    S_HALT   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [1:0] OP_FMT2  = 2'b00;
  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_MEM   = 2'b11;

  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  // op3 bit positions within ir: cc variant of arithmetic, store vs load
  localparam int unsigned OP3_CC_BIT    = 23;
  localparam int unsigned OP3_STORE_BIT = 21;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_CALL = 2'd2;

  localparam logic [3:0] COND_BA = 4'b1000;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } dec_cls_e;

  typedef struct packed {
    logic cc;
    logic is_call;
    logic is_nop;
    logic is_ba;
  } dec_flags_t;

endpackage

// File: rtl/sparc_ctrl_decode.sv
// Combinational instruction classifier: maps ir to the post-DECODE
// state class plus the flags the execute states need.
module sparc_ctrl_decode
  import sparc_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output dec_cls_e    cls_c,
  output dec_flags_t  flags_c
);

  logic [1:0] op;
  logic [2:0] op2;
  logic       unused_ir_c;

  assign op  = ir[31:30];
  assign op2 = ir[24:22];
  // annul bit and operand fields play no part in sequencing
  assign unused_ir_c = ^{ir[29], ir[20:0]};

  always_comb begin
    cls_c   = CLS_ALU;
    flags_c = '0;
    case (op)
      OP_ARITH: flags_c.cc = ir[OP3_CC_BIT];
      OP_MEM:   cls_c = ir[OP3_STORE_BIT] ? CLS_STORE : CLS_LOAD;
      OP_CALL: begin
        cls_c           = CLS_BRANCH;
        flags_c.is_call = 1'b1;
      end
      OP_FMT2: begin
        if (op2 == OP2_BICC) begin
          cls_c         = CLS_BRANCH;
          flags_c.is_ba = (ir[28:25] == COND_BA);
        end else if (op2 != OP2_SETHI) begin
          flags_c.is_nop = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/sparc_ctrl_seq.sv
// Multi-cycle control sequencer: steps the datapath through fetch, decode,
// execute, memory and write-back, with bounded RAM waits and clean halt.
module sparc_ctrl_seq
  import sparc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        moc,
  input  logic        cond_true,
  input  logic        finish,
  output logic [31:0] pc_init,
  output logic        pc_ld,
  output logic        npc_ld,
  output logic        mar_ld,
  output logic        mdr_ld,
  output logic        ir_ld,
  output logic        rf_we,
  output logic        psr_ld,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        mar_sel,
  output logic [1:0]  npc_sel,
  output logic        halted,
  output logic        trap,
  output logic [3:0]  state
);

  // counter value on the last permitted wait cycle; no moc there means trap
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  dec_flags_t flags_q, flags_d;
  dec_cls_e   dec_cls;
  dec_flags_t dec_flags;
  logic       commit;

  sparc_ctrl_decode u_decode (
    .ir      (ir),
    .cls_c   (dec_cls),
    .flags_c (dec_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    flags_d = flags_q;
    commit  = 1'b0;
    pc_ld   = 1'b0;
    npc_ld  = 1'b0;
    mar_ld  = 1'b0;
    mdr_ld  = 1'b0;
    ir_ld   = 1'b0;
    rf_we   = 1'b0;
    psr_ld  = 1'b0;
    mem_en  = 1'b0;
    mem_rw  = 1'b1;
    mar_sel = 1'b0;
    npc_sel = NPC_SEQ;

    // reset overrides everything: no enables in the cycle it is asserted
    if (!reset) begin
      case (state_q)
        S_RESET: state_d = S_FETCH;
        S_FETCH: begin
          mar_ld  = 1'b1;
          cnt_d   = '0;
          state_d = finish ? S_HALT : S_FWAIT;
        end
        S_FWAIT: begin
          mem_en = 1'b1;
          if (finish) pend_d = 1'b1;
          if (moc) begin
            ir_ld   = 1'b1;
            state_d = S_DECODE;
          end else if (cnt_q == WAIT_LAST) begin
            state_d = S_TRAP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DECODE: begin
          flags_d = dec_flags;
          case (dec_cls)
            CLS_LOAD:   state_d = S_LADDR;
            CLS_STORE:  state_d = S_SADDR;
            CLS_BRANCH: state_d = S_BRANCH;
            default:    state_d = S_ALU;
          endcase
        end
        S_ALU: begin
          rf_we  = !flags_q.is_nop;
          psr_ld = flags_q.cc;
          commit = 1'b1;
        end
        S_LADDR: begin
          mar_ld  = 1'b1;
          mar_sel = 1'b1;
          cnt_d   = '0;
          state_d = S_LWAIT;
        end
        S_LWAIT: begin
          mem_en = 1'b1;
          if (finish) pend_d = 1'b1;
          if (moc) begin
            mdr_ld  = 1'b1;
            state_d = S_LWB;
          end else if (cnt_q == WAIT_LAST) begin
            state_d = S_TRAP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_LWB: begin
          rf_we  = 1'b1;
          commit = 1'b1;
        end
        S_SADDR: begin
          mar_ld  = 1'b1;
          mar_sel = 1'b1;
          cnt_d   = '0;
          state_d = S_SWAIT;
        end
        S_SWAIT: begin
          mem_en = 1'b1;
          mem_rw = 1'b0;
          if (finish) pend_d = 1'b1;
          if (moc) begin
            commit = 1'b1;
          end else if (cnt_q == WAIT_LAST) begin
            state_d = S_TRAP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_BRANCH: begin
          if (flags_q.is_call) begin
            npc_sel = NPC_CALL;
            rf_we   = 1'b1;
          end else if (cond_true || flags_q.is_ba) begin
            npc_sel = NPC_BR;
          end
          commit = 1'b1;
        end
        S_HALT:  state_d = S_HALT;
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_RESET;
      endcase

      // shared commit: advance PC/nPC, then fetch or honour a halt request
      if (commit) begin
        pc_ld   = 1'b1;
        npc_ld  = 1'b1;
        pend_d  = 1'b0;
        state_d = (finish || pend_q) ? S_HALT : S_FETCH;
      end
    end
  end

  assign pc_init = RESET_PC;
  assign halted  = (state_q == S_HALT);
  assign trap    = (state_q == S_TRAP);
  assign state   = 4'(state_q);

endmodule
